usb_tx_packet_framer: RTL and testbench
=======================================

Name: usb_tx_packet_framer

Overview:
- Downstream neighbour of the protocol controller, which drives `tx_packet` (idle / send data / send ACK / send NACK).
- Builds the full USB packet byte stream for that request: SYNC, PID, optional payload pulled from the data buffer, CRC16 and an EOP request.
- Hands bytes to the bit-level NRZI/stuffing serializer over a valid/ready handshake.
- Pulses `tx_status` = FINISHED_SENDING when the packet completes.

Parameters:
- MAX_PACKET_BYTES, default 64: payload byte limit per data packet; larger occupancy is clamped to this value.
- OCC_WIDTH, default 7: width of `buffer_occupancy`.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- tx_packet  in  2  request from protocol controller: 00 idle, 01 send data, 10 send ACK, 11 send NACK
- buffer_occupancy  in  OCC_WIDTH  bytes currently held in the data buffer
- tx_packet_data  in  8  buffer read data, valid the cycle after `get_tx_packet_data`
- get_tx_packet_data  out  1  one-cycle buffer pop strobe
- tx_byte  out  8  byte to serializer
- tx_byte_valid  out  1  `tx_byte` is valid
- tx_byte_ready  in  1  serializer accepts the byte when valid && ready
- tx_eop  out  1  level request for the serializer to drive EOP
- tx_eop_done  in  1  one-cycle pulse from the serializer when EOP is finished
- tx_status  out  1  one-cycle pulse of 1 (FINISHED_SENDING) at packet end; 0 otherwise

Behaviour:
- **Clock and reset:** one clock, `clk`; reset `n_rst` is asynchronous and active-low.
- **Reset values:** all outputs 0. State = IDLE, data toggle = 0, CRC = 16'hFFFF, byte counter = 0.
- **States:** IDLE, SYNC, PID, FETCH, WAIT_DATA, DATA, CRC_LO, CRC_HI, EOP, DONE.
- **IDLE:**
  - On `tx_packet` != 00, latch the request type.
  - Latch count = min(`buffer_occupancy`, MAX_PACKET_BYTES); count is only used for data packets.
  - Go to SYNC.
  - `tx_packet` changes after latch are ignored until IDLE is re-entered.
- **SYNC:** `tx_byte` = 8'h80, valid = 1. On handshake, go to PID.
- **PID:**
  - `tx_byte` = 8'hD2 for ACK, 8'h5A for NACK, 8'hC3 for DATA0 (toggle = 0), 8'h4B for DATA1 (toggle = 1).
  - On handshake: ACK/NACK go to EOP.
  - Data with count = 0 goes to CRC_LO.
  - Data with count > 0 goes to FETCH; CRC is initialised to 16'hFFFF.
- **FETCH:** assert `get_tx_packet_data` for exactly one cycle, go to WAIT_DATA.
- **WAIT_DATA:** capture `tx_packet_data` into the output byte register, go to DATA.
- **DATA:**
  - Valid = 1, byte held stable until handshake.
  - On handshake: update CRC with the byte and decrement count.
  - If count becomes 0 go to CRC_LO, else go to FETCH.
  - Each byte therefore takes at least 3 cycles; no prefetch.
- **CRC update, per bit, LSB first:**
  - fb = bit ^ crc[0]; crc = crc >> 1; if fb, crc ^= 16'hA001.
  - The 8-bit step is combinational and applied once per accepted data byte.
- **CRC_LO:** `tx_byte` = ~crc[7:0]. On handshake go to CRC_HI.
- **CRC_HI:** `tx_byte` = ~crc[15:8]. On handshake go to EOP.
- **Zero-length data packet:** CRC bytes are 8'h00, 8'h00.
- **EOP:** `tx_eop` = 1, `tx_byte_valid` = 0. On `tx_eop_done` go to DONE.
- **DONE:**
  - `tx_status` = 1 for one cycle.
  - For data packets, flip the data toggle.
  - Next state IDLE. IDLE does not re-sample `tx_packet` until the following cycle, so the controller's state advance on the same edge prevents retrigger.
- **Handshake rules:**
  - `tx_byte_valid` is never deasserted, and `tx_byte` never changes, while waiting for ready.
  - `tx_byte_ready` without valid is ignored.
  - `tx_eop_done` outside the EOP state is ignored.
- **Boundary conditions:**
  - Occupancy above MAX_PACKET_BYTES sends exactly MAX_PACKET_BYTES bytes.
  - Occupancy changing mid-packet has no effect.
  - Reset mid-packet aborts immediately: no `tx_status`, toggle back to 0.

Decomposition:
- Shared package usb_pkg holds:
  - `tx_packet` codes (TX_IDLE, SEND_DATA, SEND_ACK, SEND_NACK).
  - `tx_status` codes.
  - PID byte constants and SYNC_BYTE.
  - CRC16 init/poly constants.
- Sub-module usb_crc16_byte: combinational 8-bit CRC16 step, taking crc_in and byte and producing crc_out. It is reused by the RX side for checking.

Test Plan:
- **ACK:** `tx_packet` = 10, ready always 1 → bytes 80, D2; then `tx_eop` = 1; `tx_eop_done` pulse → `tx_status` = 1 for one cycle, no `get_tx_packet_data`.
- **NACK with backpressure:** `tx_packet` = 11, ready low for 5 cycles → `tx_byte` stays 80 with valid high throughout, then 80, 5A, EOP, status pulse.
- **Zero-length data:** `tx_packet` = 01, occupancy 0 → 80, C3, 00, 00, EOP, status. Repeat → PID 4B (toggle flipped).
- **Data payload:** occupancy 4, buffer returns 00 01 02 03 → 4 pops, bytes 80 C3 00 01 02 03 followed by CRC bytes matching the bit-serial reference model, then EOP and status.
- **Clamp:** occupancy 7'd100 (above MAX_PACKET_BYTES) → exactly 64 pops and 64 payload bytes.
- **Reset mid-packet:** `n_rst` low during DATA byte 2 → all outputs 0 immediately. After release, a data request emits PID C3 (toggle = 0).

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB definitions: controller request codes, status codes, PID bytes and CRC16 constants.
// Imported by both the TX framer and the RX side.
package usb_pkg;

  localparam logic [1:0] TX_IDLE   = 2'b00;
  localparam logic [1:0] SEND_DATA = 2'b01;
  localparam logic [1:0] SEND_ACK  = 2'b10;
  localparam logic [1:0] SEND_NACK = 2'b11;

  localparam logic TX_STATUS_IDLE   = 1'b0;
  localparam logic FINISHED_SENDING = 1'b1;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NACK  = 8'h5A;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY = 16'hA001;

  function automatic logic [7:0] pid_byte(input logic [1:0] pkt, input logic toggle);
    logic [7:0] pid;
    unique case (pkt)
      SEND_ACK:  pid = PID_ACK;
      SEND_NACK: pid = PID_NACK;
      default:   pid = toggle ? PID_DATA1 : PID_DATA0;
    endcase
    return pid;
  endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// Combinational CRC16 step over one byte, bits consumed LSB first (reflected polynomial).
module usb_crc16_byte
  import usb_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  always_comb begin
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (data_in[i] ^ c[0]) begin
        c = (c >> 1) ^ CRC16_POLY;
      end else begin
        c = c >> 1;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/usb_tx_packet_framer.sv
// Builds SYNC/PID/payload/CRC16/EOP for each controller request and streams the bytes to the
// bit serializer over valid/ready; pulses tx_status when the packet has fully gone out.
module usb_tx_packet_framer
  import usb_pkg::*;
#(
  parameter int unsigned MAX_PACKET_BYTES = 64,
  parameter int unsigned OCC_WIDTH        = 7
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [1:0]           tx_packet,
  input  logic [OCC_WIDTH-1:0] buffer_occupancy,
  input  logic [7:0]           tx_packet_data,
  output logic                 get_tx_packet_data,
  output logic [7:0]           tx_byte,
  output logic                 tx_byte_valid,
  input  logic                 tx_byte_ready,
  output logic                 tx_eop,
  input  logic                 tx_eop_done,
  output logic                 tx_status
);

  localparam int unsigned CntW = $clog2(MAX_PACKET_BYTES + 1);

  typedef enum logic [3:0] {
    StIdle, StSync, StPid, StFetch, StWaitData, StData, StCrcLo, StCrcHi, StEop, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      pkt_q, pkt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            toggle_q, toggle_d;
  logic [15:0]     crc_q, crc_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            eop_q, eop_d;
  logic            get_q, get_d;
  logic            status_q, status_d;
  logic [15:0]     crc_upd;
  logic            hs;
  logic            is_data;

  usb_crc16_byte u_crc (
    .crc_in  (crc_q),
    .data_in (byte_q),
    .crc_out (crc_upd)
  );

  assign hs      = valid_q & tx_byte_ready;
  assign is_data = (pkt_q == SEND_DATA);

  always_comb begin
    state_d  = state_q;
    pkt_d    = pkt_q;
    cnt_d    = cnt_q;
    toggle_d = toggle_q;
    crc_d    = crc_q;
    byte_d   = byte_q;
    valid_d  = valid_q;
    eop_d    = eop_q;
    get_d    = 1'b0;
    status_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tx_packet != TX_IDLE) begin
          pkt_d   = tx_packet;
          cnt_d   = (32'(buffer_occupancy) > MAX_PACKET_BYTES) ? CntW'(MAX_PACKET_BYTES)
                                                               : CntW'(buffer_occupancy);
          byte_d  = SYNC_BYTE;
          valid_d = 1'b1;
          state_d = StSync;
        end
      end
      StSync: begin
        if (hs) begin
          byte_d  = pid_byte(pkt_q, toggle_q);
          state_d = StPid;
        end
      end
      StPid: begin
        if (hs) begin
          if (!is_data) begin
            valid_d = 1'b0;
            eop_d   = 1'b1;
            state_d = StEop;
          end else begin
            crc_d = CRC16_INIT;
            if (cnt_q == '0) begin
              byte_d  = ~CRC16_INIT[7:0];
              state_d = StCrcLo;
            end else begin
              valid_d = 1'b0;
              get_d   = 1'b1;
              state_d = StFetch;
            end
          end
        end
      end
      StFetch: state_d = StWaitData;
      StWaitData: begin
        byte_d  = tx_packet_data;
        valid_d = 1'b1;
        state_d = StData;
      end
      StData: begin
        if (hs) begin
          crc_d = crc_upd;
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            byte_d  = ~crc_upd[7:0];
            state_d = StCrcLo;
          end else begin
            valid_d = 1'b0;
            get_d   = 1'b1;
            state_d = StFetch;
          end
        end
      end
      StCrcLo: begin
        if (hs) begin
          byte_d  = ~crc_q[15:8];
          state_d = StCrcHi;
        end
      end
      StCrcHi: begin
        if (hs) begin
          valid_d = 1'b0;
          eop_d   = 1'b1;
          state_d = StEop;
        end
      end
      StEop: begin
        if (tx_eop_done) begin
          eop_d    = 1'b0;
          status_d = FINISHED_SENDING;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (is_data) begin
          toggle_d = ~toggle_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= StIdle;
      pkt_q    <= TX_IDLE;
      cnt_q    <= '0;
      toggle_q <= 1'b0;
      crc_q    <= CRC16_INIT;
      byte_q   <= 8'h00;
      valid_q  <= 1'b0;
      eop_q    <= 1'b0;
      get_q    <= 1'b0;
      status_q <= TX_STATUS_IDLE;
    end else begin
      state_q  <= state_d;
      pkt_q    <= pkt_d;
      cnt_q    <= cnt_d;
      toggle_q <= toggle_d;
      crc_q    <= crc_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      eop_q    <= eop_d;
      get_q    <= get_d;
      status_q <= status_d;
    end
  end

  assign tx_byte            = byte_q;
  assign tx_byte_valid      = valid_q;
  assign tx_eop             = eop_q;
  assign get_tx_packet_data = get_q;
  assign tx_status          = status_q;

endmodule

// File: tb/tb_usb_tx_packet_framer.sv
// Scoreboard bench for usb_tx_packet_framer: stimulus queues expected bytes/EOP/status events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_usb_tx_packet_framer;
  import usb_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [1:0] tx_packet;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_packet_data = 8'h00;
  logic       get_tx_packet_data;
  logic [7:0] tx_byte;
  logic       tx_byte_valid;
  logic       tx_byte_ready;
  logic       tx_eop;
  logic       tx_eop_done;
  logic       tx_status;

  usb_tx_packet_framer #(
    .MAX_PACKET_BYTES (64),
    .OCC_WIDTH        (7)
  ) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_packet          (tx_packet),
    .buffer_occupancy   (buffer_occupancy),
    .tx_packet_data     (tx_packet_data),
    .get_tx_packet_data (get_tx_packet_data),
    .tx_byte            (tx_byte),
    .tx_byte_valid      (tx_byte_valid),
    .tx_byte_ready      (tx_byte_ready),
    .tx_eop             (tx_eop),
    .tx_eop_done        (tx_eop_done),
    .tx_status          (tx_status)
  );

  always #5 clk = ~clk;

  localparam logic [9:0] EvEop    = 10'h100;
  localparam logic [9:0] EvStatus = 10'h200;

  int         checks = 0;
  int         errors = 0;
  logic [9:0] exp_q[$];
  int         pop_cnt = 0;
  int         pop_base = 0;
  int         exp_pops = 0;
  bit         bp_check = 1'b0;
  bit         final_chk = 1'b0;
  bit         final_done = 1'b0;
  int         tmo_events = 0;
  int         tmo_seen = 0;
  bit         eop_prev = 1'b0;

  // Data buffer: the i-th pop of a packet returns byte value i, valid the following cycle.
  always @(negedge clk) begin
    if (get_tx_packet_data) begin
      tx_packet_data = 8'(pop_cnt - pop_base);
      pop_cnt++;
    end
  end

  function automatic logic [15:0] crc_ref(input int n);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      b = 8'(i);
      for (int j = 0; j < 8; j++) begin
        if (b[j] ^ c[0]) c = (c >> 1) ^ 16'hA001;
        else             c = c >> 1;
      end
    end
    return c;
  endfunction

  task automatic check_evt(input logic [9:0] got, input string what);
    logic [9:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got %h, expected no event", what, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", what, got, exp);
      end
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (tmo_events != tmo_seen) begin
      checks++;
      errors += tmo_events - tmo_seen;
      $display("FAIL timeout: got %0d expired waits, expected 0", tmo_events - tmo_seen);
      tmo_seen = tmo_events;
    end
    if (!n_rst) begin
      checks++;
      if (tx_byte !== 8'h00 || tx_byte_valid !== 1'b0 || tx_eop !== 1'b0 ||
          tx_status !== 1'b0 || get_tx_packet_data !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got byte=%h v=%b eop=%b st=%b get=%b, expected all 0",
                 tx_byte, tx_byte_valid, tx_eop, tx_status, get_tx_packet_data);
      end
      eop_prev = 1'b0;
    end else begin
      if (bp_check) begin
        checks++;
        if (tx_byte_valid !== 1'b1 || tx_byte !== SYNC_BYTE) begin
          errors++;
          $display("FAIL backpressure_hold: got v=%b byte=%h, expected v=1 byte=80",
                   tx_byte_valid, tx_byte);
        end
      end
      if (tx_eop) begin
        checks++;
        if (tx_byte_valid !== 1'b0) begin
          errors++;
          $display("FAIL eop_valid: got valid=%b, expected 0", tx_byte_valid);
        end
      end
      if (tx_byte_valid && tx_byte_ready) check_evt({2'b00, tx_byte}, "byte");
      if (tx_eop && !eop_prev) check_evt(EvEop, "eop");
      if (tx_status) begin
        check_evt(EvStatus, "status");
        checks++;
        if (pop_cnt - pop_base != exp_pops) begin
          errors++;
          $display("FAIL pop_count: got %0d, expected %0d", pop_cnt - pop_base, exp_pops);
        end
      end
      eop_prev = tx_eop;
    end
    if (final_chk && !final_done) begin
      final_done = 1'b1;
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL leftover_events: got %0d pending, expected 0", exp_q.size());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    exp_q.push_back({2'b00, b});
  endtask

  task automatic push_payload(input int n);
    logic [15:0] c;
    logic [7:0]  lo;
    logic [7:0]  hi;
    for (int i = 0; i < n; i++) push(8'(i));
    c  = crc_ref(n);
    lo = ~c[7:0];
    hi = ~c[15:8];
    push(lo);
    push(hi);
  endtask

  task automatic push_tail();
    exp_q.push_back(EvEop);
    exp_q.push_back(EvStatus);
  endtask

  task automatic request(input logic [1:0] code, input logic [6:0] occ, input int pops);
    pop_base         = pop_cnt;
    exp_pops         = pops;
    tx_packet        = code;
    buffer_occupancy = occ;
    step(1);
    tx_packet = TX_IDLE;
  endtask

  task automatic finish_packet();
    int n;
    n = 0;
    while (!tx_eop && n < 3000) begin
      step(1);
      n++;
    end
    if (!tx_eop) begin
      tmo_events++;
    end else begin
      step(2);
      tx_eop_done = 1'b1;
      step(1);
      tx_eop_done = 1'b0;
      step(3);
    end
  endtask

  initial begin
    int n;
    n_rst            = 1'b0;
    tx_packet        = TX_IDLE;
    buffer_occupancy = '0;
    tx_byte_ready    = 1'b0;
    tx_eop_done      = 1'b0;
    step(3);
    n_rst = 1'b1;
    step(2);

    // Stray ready / eop_done while idle must produce nothing.
    tx_byte_ready = 1'b1;
    tx_eop_done   = 1'b1;
    step(1);
    tx_eop_done = 1'b0;
    step(2);

    // ACK
    push(SYNC_BYTE); push(8'hD2); push_tail();
    request(SEND_ACK, 7'd5, 0);
    finish_packet();

    // NACK with backpressure on SYNC
    tx_byte_ready = 1'b0;
    push(SYNC_BYTE); push(8'h5A); push_tail();
    request(SEND_NACK, 7'd0, 0);
    step(1);
    bp_check = 1'b1;
    step(5);
    bp_check      = 1'b0;
    tx_byte_ready = 1'b1;
    finish_packet();

    // Zero-length data twice: DATA0 then DATA1
    push(SYNC_BYTE); push(8'hC3); push(8'h00); push(8'h00); push_tail();
    request(SEND_DATA, 7'd0, 0);
    finish_packet();
    push(SYNC_BYTE); push(8'h4B); push(8'h00); push(8'h00); push_tail();
    request(SEND_DATA, 7'd0, 0);
    finish_packet();

    // Four-byte payload; occupancy changes after latch must not matter
    push(SYNC_BYTE); push(8'hC3); push_payload(4); push_tail();
    request(SEND_DATA, 7'd4, 4);
    buffer_occupancy = 7'd9;
    finish_packet();

    // Reset during the second payload byte (toggle is 1 here)
    push(SYNC_BYTE); push(8'h4B); push(8'h00);
    request(SEND_DATA, 7'd4, 4);
    n = 0;
    while (pop_cnt - pop_base < 2 && n < 200) begin
      step(1);
      n++;
    end
    if (pop_cnt - pop_base < 2) tmo_events++;
    tx_byte_ready = 1'b0;
    step(1);
    n_rst = 1'b0;
    step(2);
    n_rst         = 1'b1;
    tx_byte_ready = 1'b1;
    step(2);

    // After reset the toggle is back to DATA0
    push(SYNC_BYTE); push(8'hC3); push(8'h00); push(8'h00); push_tail();
    request(SEND_DATA, 7'd0, 0);
    finish_packet();

    // Clamp: occupancy 100 sends exactly 64 bytes
    push(SYNC_BYTE); push(8'h4B); push_payload(64); push_tail();
    request(SEND_DATA, 7'd100, 64);
    finish_packet();

    final_chk = 1'b1;
    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
